async_tracking_fifo: RTL and testbench

Parametrised dual-clock FIFO for the converter data paths: data is written in the `clk_in` domain and read in the `clk_out` domain. Both domains get their live memory addresses and a fill count. Pointers cross domains as Gray codes through two-flop synchronisers, so full and empty are safe in both domains. Overflow and underflow attempts are refused and flagged with sticky bits. It replaces fixed 8-bit/2k FIFO instances between the USB/host side and the DAC/ADC channel logic.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/async_tracking_fifo.sv | 137 +++++++++++++
 tb/tb_async_tracking_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers for the dual-clock FIFO pointers.
// Callers zero-extend pointers up to 32 bits and cast the result back.
package fifo_pkg;

    localparam int GW = 32;

    function automatic logic [GW-1:0] bin2gray(
        input logic [GW-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(
        input logic [GW-1:0] g
    );
        logic [GW-1:0] b;
        b = g;
        for (int i = 1; i < GW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage flop synchroniser with optional sync clear.
// Inputs must come straight from a register in the source domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/async_tracking_fifo.sv
// async_tracking_fifo: dual-clock FIFO with Gray pointer crossings,
// fill counts and sticky overflow/underflow flags in each domain.
module async_tracking_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk_in,
    input  logic                 clk_out,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 write_in,
    output logic                 full,
    output logic [ADDR_BITS:0]   wr_count,
    output logic [ADDR_BITS-1:0] addr_in,
    output logic                 overflow,
    input  logic                 read_out,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic                 empty,
    output logic [ADDR_BITS:0]   rd_count,
    output logic [ADDR_BITS-1:0] addr_out,
    output logic                 underflow
);

    localparam int PW    = ADDR_BITS + 1;
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_wr_gray;
    logic [PW-1:0] w_wr_bin_nxt;
    logic [PW-1:0] w_rd_gray_sync;
    logic [PW-1:0] w_rd_bin_sync;
    logic          r_overflow;
    logic          w_wr_en;

    logic [PW-1:0]    r_rd_bin;
    logic [PW-1:0]    r_rd_gray;
    logic [PW-1:0]    w_rd_bin_nxt;
    logic [PW-1:0]    w_wr_gray_sync;
    logic [PW-1:0]    w_wr_bin_sync;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_underflow;
    logic             w_rd_en;
    logic             w_rd_reset;

    sync_2ff #(.WIDTH(1)) u_rst_sync (
        .i_clk (clk_out),
        .i_rst (1'b0),
        .i_d   (reset),
        .o_q   (w_rd_reset)
    );

    sync_2ff #(.WIDTH(PW)) u_wr2rd (
        .i_clk (clk_out),
        .i_rst (w_rd_reset),
        .i_d   (r_wr_gray),
        .o_q   (w_wr_gray_sync)
    );

    sync_2ff #(.WIDTH(PW)) u_rd2wr (
        .i_clk (clk_in),
        .i_rst (reset),
        .i_d   (r_rd_gray),
        .o_q   (w_rd_gray_sync)
    );

    assign w_wr_en       = write_in && !full;
    assign w_wr_bin_nxt  = r_wr_bin + PW'(1);
    assign w_rd_bin_sync = PW'(gray2bin(32'(w_rd_gray_sync)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_wr_bin   <= '0;
            r_wr_gray  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_bin  <= w_wr_bin_nxt;
                r_wr_gray <= PW'(bin2gray(32'(w_wr_bin_nxt)));
            end
            if (write_in && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[r_wr_bin[ADDR_BITS-1:0]] <= data_in;
        end
    end

    // Full in Gray space: same low bits, top two bits inverted.
    assign full = (r_wr_gray ==
                   {~w_rd_gray_sync[PW-1:PW-2],
                    w_rd_gray_sync[PW-3:0]});
    assign wr_count = r_wr_bin - w_rd_bin_sync;
    assign addr_in  = r_wr_bin[ADDR_BITS-1:0];
    assign overflow = r_overflow;

    assign w_rd_en       = read_out && !empty;
    assign w_rd_bin_nxt  = r_rd_bin + PW'(1);
    assign w_wr_bin_sync = PW'(gray2bin(32'(w_wr_gray_sync)));

    always_ff @(posedge clk_out) begin
        if (w_rd_reset) begin
            r_rd_bin     <= '0;
            r_rd_gray    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_data_valid <= w_rd_en;
            if (w_rd_en) begin
                r_data_out <= r_mem[r_rd_bin[ADDR_BITS-1:0]];
                r_rd_bin   <= w_rd_bin_nxt;
                r_rd_gray  <= PW'(bin2gray(32'(w_rd_bin_nxt)));
            end
            if (read_out && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign empty      = (r_rd_gray == w_wr_gray_sync);
    assign rd_count   = w_wr_bin_sync - r_rd_bin;
    assign addr_out   = r_rd_bin[ADDR_BITS-1:0];
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_async_tracking_fifo.sv
// tb_async_tracking_fifo: directed and streamed checks of the
// dual-clock FIFO with a queue scoreboard, ADDR_BITS = 4.
`timescale 1ns/1ps
module tb_async_tracking_fifo;

    localparam int AB = 4;
    localparam int D  = 16;

    logic          clk_in   = 1'b0;
    logic          clk_out  = 1'b0;
    logic          reset    = 1'b1;
    logic [7:0]    data_in  = '0;
    logic          write_in = 1'b0;
    logic          read_out = 1'b0;
    logic          full, overflow, empty, underflow, data_valid;
    logic [AB:0]   wr_count, rd_count;
    logic [AB-1:0] addr_in, addr_out;
    logic [7:0]    data_out;

    real p_in  = 10.0;
    real p_out = 27.027;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];

    logic          mon_en  = 1'b0;
    int            viol_w  = 0;
    int            viol_r  = 0;
    int            wraps_i = 0;
    int            wraps_o = 0;
    logic [AB-1:0] pai     = '0;
    logic [AB-1:0] pao     = '0;

    always #(p_in / 2.0) clk_in = ~clk_in;
    always #(p_out / 2.0) clk_out = ~clk_out;

    async_tracking_fifo #(.WIDTH(8), .ADDR_BITS(AB)) dut (
        .clk_in     (clk_in),
        .clk_out    (clk_out),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .full       (full),
        .wr_count   (wr_count),
        .addr_in    (addr_in),
        .overflow   (overflow),
        .read_out   (read_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .empty      (empty),
        .rd_count   (rd_count),
        .addr_out   (addr_out),
        .underflow  (underflow)
    );

    always @(negedge clk_in) begin
        pai <= addr_in;
        if (mon_en) begin
            if (full !== (wr_count == D) || wr_count > D ||
                $isunknown({full, wr_count, addr_in, overflow}))
                viol_w <= viol_w + 1;
            if (pai == 4'd15 && addr_in == 4'd0)
                wraps_i <= wraps_i + 1;
        end
    end

    always @(negedge clk_out) begin
        pao <= addr_out;
        if (mon_en) begin
            if (empty !== (rd_count == 0) || rd_count > D ||
                $isunknown({empty, rd_count, addr_out,
                            underflow, data_valid, data_out}))
                viol_r <= viol_r + 1;
            if (pao == 4'd15 && addr_out == 4'd0)
                wraps_o <= wraps_o + 1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset    = 1'b1;
        write_in = 1'b0;
        read_out = 1'b0;
        repeat (5) @(posedge clk_out);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (4) @(posedge clk_out);
        @(negedge clk_out);
        sb.delete();
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk_in);
        data_in  = d;
        write_in = 1'b1;
        @(negedge clk_in);
        write_in = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        @(negedge clk_out);
        read_out = 1'b1;
        @(negedge clk_out);
        read_out = 1'b0;
        chk({tag, "_valid"}, 32'(data_valid), 32'd1);
        chk({tag, "_data"}, 32'(data_out), 32'(exp));
    endtask

    task automatic wait_rdc(input int n);
        for (int k = 0; k < 20 && rd_count != n; k++)
            @(negedge clk_out);
    endtask

    task automatic wait_wrc(input int n);
        for (int k = 0; k < 20 && wr_count != n; k++)
            @(negedge clk_in);
    endtask

    task automatic stream(input string tag, input int n,
                          input int wpct, input int rpct);
        int sent, got, cw, cr;
        logic pend;
        logic [7:0] e;
        sent = 0;
        got  = 0;
        cw   = 0;
        cr   = 0;
        pend = 1'b0;
        fork
            begin
                while (sent < n && cw < 20000) begin
                    @(negedge clk_in);
                    cw++;
                    if (!full && $urandom_range(99) < wpct) begin
                        data_in  = 8'(sent);
                        write_in = 1'b1;
                        sb.push_back(8'(sent));
                        sent++;
                    end else begin
                        write_in = 1'b0;
                    end
                end
                @(negedge clk_in);
                write_in = 1'b0;
            end
            begin
                while (got < n && cr < 20000) begin
                    @(negedge clk_out);
                    cr++;
                    chk({tag, "_valid"}, 32'(data_valid), 32'(pend));
                    if (pend) begin
                        if (sb.size() == 0) begin
                            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
                        end else begin
                            e = sb.pop_front();
                            chk({tag, "_data"}, 32'(data_out), 32'(e));
                        end
                        got++;
                    end
                    if (got < n && !empty &&
                        $urandom_range(99) < rpct) begin
                        read_out = 1'b1;
                        pend     = 1'b1;
                    end else begin
                        read_out = 1'b0;
                        pend     = 1'b0;
                    end
                end
                read_out = 1'b0;
            end
        join
        chk({tag, "_sent"}, 32'(sent), 32'(n));
        chk({tag, "_got"}, 32'(got), 32'(n));
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int v0w, v0r, w0i, w0o;
        logic [7:0] t1 [4];
        real pouts [3];
        t1    = '{8'h11, 8'h22, 8'h33, 8'h44};
        pouts = '{40.0, 10.0, 2.5};

        do_reset();
        chk("rst_addr_in", 32'(addr_in), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        wr(t1[0]);
        edges = 0;
        while (empty !== 1'b0 && edges < 4) begin
            @(posedge clk_out);
            #1;
            edges++;
        end
        chk("t1_empty_lat_le3", 32'(edges <= 3), 32'd1);
        chk("t1_empty_fell", 32'(empty), 32'd0);
        for (int i = 1; i < 4; i++) wr(t1[i]);
        wait_rdc(4);
        chk("t1_rd_count4", 32'(rd_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd("t1_rd", t1[i]);
            chk("t1_rd_count", 32'(rd_count), 32'(3 - i));
        end
        chk("t1_empty_after", 32'(empty), 32'd1);

        do_reset();
        for (int i = 0; i < D; i++) wr(8'(8'hA0 + i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_wr_count", 32'(wr_count), 32'd16);
        chk("t2_addr_in", 32'(addr_in), 32'd0);
        chk("t2_no_ovf_yet", 32'(overflow), 32'd0);
        wr(8'hFF);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_full_hold", 32'(full), 32'd1);
        chk("t2_wr_count_hold", 32'(wr_count), 32'd16);
        chk("t2_addr_in_hold", 32'(addr_in), 32'd0);
        wait_rdc(16);
        chk("t2_rd_count16", 32'(rd_count), 32'd16);
        for (int i = 0; i < D; i++) rd("t2_drain", 8'(8'hA0 + i));
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_rd_count0", 32'(rd_count), 32'd0);
        wait_wrc(0);
        chk("t2_wr_count_freed", 32'(wr_count), 32'd0);
        chk("t2_full_freed", 32'(full), 32'd0);

        chk("t3_underflow_pre", 32'(underflow), 32'd0);
        @(negedge clk_out);
        read_out = 1'b1;
        @(negedge clk_out);
        read_out = 1'b0;
        chk("t3_underflow", 32'(underflow), 32'd1);
        chk("t3_valid", 32'(data_valid), 32'd0);
        chk("t3_data_hold", 32'(data_out), 32'hAF);
        chk("t3_addr_out_hold", 32'(addr_out), 32'd0);

        for (int i = 0; i < 10; i++) wr(8'(8'h50 + i));
        wait_rdc(10);
        chk("t5_rd_count10", 32'(rd_count), 32'd10);
        chk("t5_ovf_pre", 32'(overflow), 32'd1);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        chk("t5_addr_in", 32'(addr_in), 32'd0);
        chk("t5_wr_count", 32'(wr_count), 32'd0);
        chk("t5_full", 32'(full), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        repeat (3) @(posedge clk_out);
        #1;
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_rd_count", 32'(rd_count), 32'd0);
        chk("t5_underflow", 32'(underflow), 32'd0);
        chk("t5_data_out", 32'(data_out), 32'd0);
        chk("t5_valid", 32'(data_valid), 32'd0);
        chk("t5_addr_out", 32'(addr_out), 32'd0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (4) @(posedge clk_out);
        @(negedge clk_out);
        sb.delete();

        v0w = viol_w; v0r = viol_r;
        w0i = wraps_i; w0o = wraps_o;
        mon_en = 1'b1;
        stream("t4", 100, 100, 100);
        @(negedge clk_in);
        mon_en = 1'b0;
        chk("t4_wrap_in", 32'(wraps_i > w0i), 32'd1);
        chk("t4_wrap_out", 32'(wraps_o > w0o), 32'd1);
        chk("t4_flags_w", 32'(viol_w - v0w), 32'd0);
        chk("t4_flags_r", 32'(viol_r - v0r), 32'd0);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_underflow", 32'(underflow), 32'd0);

        for (int r = 0; r < 3; r++) begin
            p_in  = 10.0;
            p_out = pouts[r];
            do_reset();
            v0w = viol_w;
            v0r = viol_r;
            mon_en = 1'b1;
            stream($sformatf("t6_r%0d", r), 150, 60, 60);
            @(negedge clk_in);
            @(negedge clk_out);
            mon_en = 1'b0;
            chk("t6_flags_w", 32'(viol_w - v0w), 32'd0);
            chk("t6_flags_r", 32'(viol_r - v0r), 32'd0);
            chk("t6_overflow", 32'(overflow), 32'd0);
            chk("t6_underflow", 32'(underflow), 32'd0);
            chk("t6_empty_end", 32'(empty), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
